// File: rtl/uart_tx_nibble_fifo_if.sv
// Host-side bundle for uart_tx_nibble_fifo: nibble/mode load port plus serial line and status.
// dbg_state mirrors the transmitter FSM encoding.
interface uart_tx_nibble_fifo_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [3:0]       nibble;
    logic [1:0]       mode;
    logic             tx;
    logic             busy;
    logic             fifo_empty;
    logic             fifo_full;
    logic [CNT_W-1:0] fifo_count;
    logic             overflow;
    logic [2:0]       dbg_state;

    modport master (
        output nibble, mode,
        input  tx, busy, fifo_empty, fifo_full, fifo_count, overflow, dbg_state
    );

    modport slave (
        input  nibble, mode,
        output tx, busy, fifo_empty, fifo_full, fifo_count, overflow, dbg_state
    );
endinterface

// File: rtl/uart_tx_nibble_fifo.sv
// UART transmitter fed by nibble-pair pushes into a byte FIFO; LSB-first, 1 or 2 stop bits.
// Optional parity bit after the data bits when UART_PARITY_EN is defined.
module uart_tx_nibble_fifo #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 256,
    parameter int FIFO_DEPTH   = 4,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_tx_nibble_fifo_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(STOP_BITS * CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [TMR_W-1:0] BIT_RELOAD  = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [TMR_W-1:0] STOP_RELOAD = TMR_W'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT    = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] MODE_LSB  = 2'b01;
    localparam logic [1:0] MODE_PUSH = 2'b10;
    localparam logic [1:0] MODE_TX   = 2'b11;

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t               state_q, state_d;
    logic [TMR_W-1:0]     tmr_q, tmr_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [1:0]           prev_mode_q;
    logic [3:0]           lsb_q;
    logic [7:0]           mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 empty_q, full_q, overflow_q;
    logic                 push, push_ok, pop, can_start, tx_bit;
    logic [7:0]           head;

    assign head      = mem_q[rd_ptr_q];
    assign can_start = (bus.mode == MODE_TX) && (count_q != '0);
    assign push      = (bus.mode == MODE_PUSH) && (prev_mode_q != MODE_PUSH);
    // A push into a full FIFO survives only if the same edge frees a slot.
    assign push_ok   = push && ((count_q != FULL_CNT) || pop);

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_mode_q <= 2'b00;
            lsb_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            prev_mode_q <= bus.mode;
            if (bus.mode == MODE_LSB) lsb_q <= bus.nibble;
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !push_ok) overflow_q <= 1'b1;
            count_q <= count_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == FULL_CNT);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push_ok) mem_q[wr_ptr_q] <= {bus.nibble, lsb_q};
    end

`ifdef UART_PARITY_EN
    logic par_q, par_d;
    always_ff @(posedge clk) begin
        if (reset) par_q <= 1'b0;
        else       par_q <= par_d;
    end
`else
    logic unused_parity_odd;
    assign unused_parity_odd = (PARITY_ODD != 0);
`endif

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        tx_bit  = 1'b1;
`ifdef UART_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE, S_STOP: begin
                if (state_q == S_STOP && tmr_q != '0) begin
                    tmr_d = tmr_q - 1'b1;
                end else if (can_start) begin
                    pop     = 1'b1;
                    state_d = S_START;
                    tmr_d   = BIT_RELOAD;
                    shift_d = head[DATA_BITS-1:0];
`ifdef UART_PARITY_EN
                    par_d   = (^head[DATA_BITS-1:0]) ^ (PARITY_ODD != 0);
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                tx_bit = 1'b0;
                if (tmr_q == '0) begin
                    state_d = S_DATA;
                    tmr_d   = BIT_RELOAD;
                    bit_d   = '0;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_DATA: begin
                tx_bit = shift_q[0];
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - 1'b1;
                end else if (bit_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
                    state_d = S_PARITY;
                    tmr_d   = BIT_RELOAD;
`else
                    state_d = S_STOP;
                    tmr_d   = STOP_RELOAD;
`endif
                end else begin
                    tmr_d   = BIT_RELOAD;
                    bit_d   = bit_q + 1'b1;
                    shift_d = shift_q >> 1;
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                tx_bit = par_q;
                if (tmr_q == '0) begin
                    state_d = S_STOP;
                    tmr_d   = STOP_RELOAD;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    assign bus.tx         = tx_bit;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.fifo_empty = empty_q;
    assign bus.fifo_full  = full_q;
    assign bus.fifo_count = count_q;
    assign bus.overflow   = overflow_q;
    assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_uart_tx_nibble_fifo.sv
// Directed bench for uart_tx_nibble_fifo with CLKS_PER_BIT=4, DATA_BITS=8, FIFO_DEPTH=4, STOP_BITS=1.
// Frame waveforms are checked cycle by cycle against a bit-slot model of the expected line.
module tb_uart_tx_nibble_fifo;
  localparam int CPB = 4;
`ifdef UART_PARITY_EN
  localparam int FRAME_LEN = (2 + 8 + 1) * CPB;
`else
  localparam int FRAME_LEN = (1 + 8 + 1) * CPB;
`endif

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  logic [7:0] exp_q[$];

  uart_tx_nibble_fifo_if #(.FIFO_DEPTH(4)) bus ();

  uart_tx_nibble_fifo #(
    .DATA_BITS(8), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .STOP_BITS(1), .PARITY_ODD(0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] word, input int i);
    int slot;
    slot = i / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return word[slot-1];
`ifdef UART_PARITY_EN
    if (slot == 9) return ^word;
`endif
    return 1'b1;
  endfunction

  // driver
  task automatic push_word(input logic [7:0] w);
    bus.mode = 2'b01; bus.nibble = w[3:0]; step();
    bus.mode = 2'b10; bus.nibble = w[7:4]; step();
    bus.mode = 2'b00; step();
  endtask

  // Checks n cycles of a frame starting at the current sample; drops mode to 00 at cycle drop_at.
  task automatic check_frame(input logic [7:0] word, input int drop_at, input int n);
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("tx[%0h][%0d]", word, i), 32'(bus.tx), 32'(exp_bit(word, i)));
      check_eq($sformatf("busy[%0h][%0d]", word, i), 32'(bus.busy), 32'd1);
      if (i == drop_at) bus.mode = 2'b00;
      step();
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    bus.mode = 2'b00;
    bus.nibble = 4'h0;

    // 1. reset
    reset = 1'b1;
    step(); step();
    check_eq("rst_tx", 32'(bus.tx), 32'd1);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_empty", 32'(bus.fifo_empty), 32'd1);
    check_eq("rst_full", 32'(bus.fifo_full), 32'd0);
    check_eq("rst_count", 32'(bus.fifo_count), 32'd0);
    check_eq("rst_ovf", 32'(bus.overflow), 32'd0);
    reset = 1'b0;

    // 2. single frame, mode 10 held three cycles pushes once
    bus.mode = 2'b01; bus.nibble = 4'h5; step();
    bus.mode = 2'b10; bus.nibble = 4'hA; step(); step(); step();
    check_eq("single_count", 32'(bus.fifo_count), 32'd1);
    check_eq("single_empty", 32'(bus.fifo_empty), 32'd0);
    bus.mode = 2'b11; step();
    check_eq("single_empty_after_pop", 32'(bus.fifo_empty), 32'd1);
    check_frame(8'hA5, -1, FRAME_LEN);
    check_eq("single_busy_end", 32'(bus.busy), 32'd0);
    check_eq("single_tx_end", 32'(bus.tx), 32'd1);

    // 3. overflow: fifth push dropped
    bus.mode = 2'b00; step();
    push_word(8'h11); push_word(8'h22); push_word(8'h33); push_word(8'h44);
    check_eq("ovf_before", 32'(bus.overflow), 32'd0);
    push_word(8'h55);
    check_eq("ovf_full", 32'(bus.fifo_full), 32'd1);
    check_eq("ovf_count", 32'(bus.fifo_count), 32'd4);
    check_eq("ovf_flag", 32'(bus.overflow), 32'd1);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    exp_q.push_back(8'h33); exp_q.push_back(8'h44);
    bus.mode = 2'b11; step();
    while (exp_q.size() > 0) check_frame(exp_q.pop_front(), -1, FRAME_LEN);
    check_eq("ovf_drain_busy", 32'(bus.busy), 32'd0);
    check_eq("ovf_drain_empty", 32'(bus.fifo_empty), 32'd1);
    check_eq("ovf_sticky", 32'(bus.overflow), 32'd1);
    bus.mode = 2'b00;
    reset = 1'b1; step(); reset = 1'b0;
    check_eq("ovf_cleared", 32'(bus.overflow), 32'd0);

    // 4. back-to-back frames are gapless
    push_word(8'h00); push_word(8'hFF);
    check_eq("b2b_count", 32'(bus.fifo_count), 32'd2);
    bus.mode = 2'b11; step();
    check_frame(8'h00, -1, FRAME_LEN);
    check_frame(8'hFF, -1, FRAME_LEN);
    check_eq("b2b_busy_end", 32'(bus.busy), 32'd0);

    // 5. mode leaves 11 mid-frame
    bus.mode = 2'b00; step();
    push_word(8'h3C); push_word(8'hC3);
    bus.mode = 2'b11; step();
    check_frame(8'h3C, 10, FRAME_LEN);
    check_eq("dis_busy", 32'(bus.busy), 32'd0);
    check_eq("dis_tx", 32'(bus.tx), 32'd1);
    check_eq("dis_count", 32'(bus.fifo_count), 32'd1);
    step();
    check_eq("dis_stay_idle", 32'(bus.busy), 32'd0);

    // 6. reset mid-frame
    bus.mode = 2'b11; step();
    check_frame(8'hC3, -1, 15);
    reset = 1'b1; step();
    check_eq("rmid_tx", 32'(bus.tx), 32'd1);
    check_eq("rmid_busy", 32'(bus.busy), 32'd0);
    check_eq("rmid_count", 32'(bus.fifo_count), 32'd0);
    check_eq("rmid_empty", 32'(bus.fifo_empty), 32'd1);
    reset = 1'b0;
    bus.mode = 2'b00;
    step();
    check_eq("rmid_idle", 32'(bus.busy), 32'd0);

`ifdef UART_PARITY_EN
    // parity frame for 0xA5: parity 0 at cycles 36..39, 44-cycle frame
    push_word(8'hA5);
    bus.mode = 2'b11; step();
    bus.mode = 2'b00;
    check_frame(8'hA5, -1, FRAME_LEN);
    check_eq("par_busy_end", 32'(bus.busy), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
